config_writer: RTL and testbench
================================

Name: config_writer

Overview:
Serializes a switch connection table into the binary ATGF configuration image in a word-addressed RAM. The image is later consumed by the configuration parsing logic. Software or a control FSM opens a session, pushes connection records one at a time over a valid/ready handshake, then finishes. The block writes each record as 11 words and writes the 4-word header last, so a valid magic number always marks a complete image.

Parameters:
MAX_CONNECTIONS, 64, maximum records per image; further records are dropped and flagged.
ADDR_WIDTH, 32, width of the memory byte address.
BASE_ADDR, 0, byte address of the image header.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_addr  out  ADDR_WIDTH  byte address of the current write
mem_wdata  out  32  write data
mem_we  out  1  write request; completes on a cycle where mem_we and mem_ready are both high
mem_ready  in  1  memory accepts the write
cfg_start  in  1  pulse; opens a session (accepted in IDLE or DONE only)
cfg_version  in  32  header version, sampled at cfg_start
cfg_timestamp  in  32  header timestamp, sampled at cfg_start
cfg_finish  in  1  pulse; closes the session and writes the header
conn_wr_valid  in  1  a connection record is presented
conn_wr_ready  out  1  the record is accepted on valid&&ready
conn_switch_id, conn_host_id, conn_my_ip, conn_peer_ip  in  32 each  record fields
conn_my_port, conn_peer_port, conn_my_qp, conn_peer_qp  in  16 each  record fields
conn_my_mac, conn_peer_mac  in  48 each  MAC addresses, [47:40] = first byte
conn_up  in  1  link-up flag
busy  out  1  high in WR_CONN and WR_HDR
done  out  1  high in DONE, until the next cfg_start or reset
write_error  out  1  sticky overflow flag; cleared by cfg_start or reset
conn_count  out  $clog2(MAX_CONNECTIONS+1)  number of records written this session

Behaviour:
- Reset: state IDLE. mem_addr=0, mem_wdata=0, mem_we=0, conn_wr_ready=0, busy=0, done=0, write_error=0, conn_count=0, finish_pending=0. Reset mid-write drops mem_we on the next edge; no further writes occur.
- States:
  - IDLE or DONE: on cfg_start, latch version and timestamp, clear conn_count and write_error, go to OPEN.
  - OPEN: conn_wr_ready=1 unless finish_pending. A handshake packs the record into an 11-word buffer and moves to WR_CONN on the next edge. A finish with no pending record moves to WR_HDR.
  - WR_CONN: issues words 0..10 at BASE_ADDR+16+conn_count*44+4*k. After word 10 completes, conn_count increments. The FSM then returns to OPEN, or goes to WR_HDR if finish_pending is set.
  - WR_HDR: issues words 0..3 at BASE_ADDR+4*k, then goes to DONE.
- Record packing:
  - w0 switch_id; w1 host_id; w2 my_ip; w3 peer_ip.
  - w4 {peer_port, my_port}; w5 {peer_qp, my_qp}.
  - w6 {my_mac[23:16], my_mac[31:24], my_mac[39:32], my_mac[47:40]}.
  - w7 {peer_mac[39:32], peer_mac[47:40], my_mac[7:0], my_mac[15:8]}.
  - w8 {peer_mac[7:0], peer_mac[15:8], peer_mac[23:16], peer_mac[31:24]}.
  - w9 {31'b0, up}; w10 = 0.
- Header: w0 = 32'h41544746; w1 = version; w2 = conn_count zero-extended; w3 = timestamp.
- Memory handshake:
  - mem_addr, mem_wdata and mem_we are registered.
  - While mem_we=1 and mem_ready=0, all three hold stable; the word counter advances only on accept.
  - With mem_ready held at 1, a record occupies exactly 11 consecutive mem_we cycles and the header exactly 4.
  - mem_we is 0 outside WR_CONN and WR_HDR.
- cfg_finish latches finish_pending in any of OPEN or WR_CONN, including the same cycle as a record handshake. The record is written first, then the header. finish_pending clears on entry to DONE.
- Overflow: a handshake when conn_count == MAX_CONNECTIONS is accepted and dropped. No write occurs, write_error is set, and the FSM stays in OPEN.
- Ignored inputs: cfg_start in OPEN, WR_CONN or WR_HDR; cfg_finish in IDLE or DONE; conn_wr_valid outside OPEN.

Test Plan:
1. Assert rst for 2 cycles mid-WR_CONN -> next cycle mem_we=0; all outputs at reset values; state IDLE; no further writes.
2. start (version=1, timestamp=0x12345678); one record (switch_id=3, my_mac=48'h001122334455, up=1); finish; mem_ready=1 -> writes 0x10..0x38 (11 words), w6=0x33221100, w7=0x????5544 with low half 0x5544, w9=1, then header at 0x0..0xC = 0x41544746, 1, 1, 0x12345678; done=1.
3. Same as 2 with mem_ready toggling 1,0,0,1 -> each word held stable while stalled; image contents identical; 15 accepted writes total.
4. MAX_CONNECTIONS=2, push 3 records then finish -> third record dropped; write_error=1; header w2=2; no write at 0x68.
5. cfg_finish in the same cycle as the second record handshake -> second record written at 0x3C..0x64 before the header; header w2=2.
6. start then finish with no records -> only the 4 header writes, w2=0; second cfg_start from DONE clears done, write_error and conn_count.

Source files
------------

// File: rtl/config_writer.sv
// config_writer
//   Serializes a switch connection table into the ATGF configuration image
//   held in a word-addressed RAM. Each connection record becomes 11 words at
//   BASE_ADDR+16+n*44. The 4-word header at BASE_ADDR is written last, so a
//   valid magic number only ever marks a complete image.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   mem_addr/wdata/we  registered write request, held while mem_ready is low
//   mem_ready          memory accepts the write presented this cycle
//   cfg_start          opens a session (IDLE/DONE), samples version/timestamp
//   cfg_finish         closes the session; header is written after any record
//   conn_wr_*          record push over a valid/ready handshake
//   busy, done         status: writing / image complete
//   write_error        sticky: a record arrived with the table already full
//   conn_count         records written in this session
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no session since reset
// OPEN     | session open, accepting connection records
// WR_CONN  | writing the buffered 11-word record
// WR_HDR   | writing the 4-word header
// DONE     | image complete, waiting for a new session
module config_writer #(
  parameter int                    MAX_CONNECTIONS = 64,
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic [ADDR_WIDTH-1:0]                  mem_addr,
  output logic [31:0]                            mem_wdata,
  output logic                                   mem_we,
  input  logic                                   mem_ready,
  input  logic                                   cfg_start,
  input  logic [31:0]                            cfg_version,
  input  logic [31:0]                            cfg_timestamp,
  input  logic                                   cfg_finish,
  input  logic                                   conn_wr_valid,
  output logic                                   conn_wr_ready,
  input  logic [31:0]                            conn_switch_id,
  input  logic [31:0]                            conn_host_id,
  input  logic [31:0]                            conn_my_ip,
  input  logic [31:0]                            conn_peer_ip,
  input  logic [15:0]                            conn_my_port,
  input  logic [15:0]                            conn_peer_port,
  input  logic [15:0]                            conn_my_qp,
  input  logic [15:0]                            conn_peer_qp,
  input  logic [47:0]                            conn_my_mac,
  input  logic [47:0]                            conn_peer_mac,
  input  logic                                   conn_up,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   write_error,
  output logic [$clog2(MAX_CONNECTIONS+1)-1:0]   conn_count
);

  localparam int          CW    = $clog2(MAX_CONNECTIONS+1);
  localparam logic [31:0] MAGIC = 32'h41544746;

  typedef enum logic [2:0] {
    S_IDLE, S_OPEN, S_WR_CONN, S_WR_HDR, S_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [3:0]              word_idx, sel_idx;
  logic [31:0]             version_q, timestamp_q;
  logic                    finish_pending;
  logic [31:0]             rec_buf [9];
  logic                    rec_up;
  logic                    hs, overflow, accept, last_word, finish_req;
  logic [31:0]             rec_word, hdr_word, issue_data;
  logic [ADDR_WIDTH-1:0]   rec_base, issue_addr;

  assign hs         = conn_wr_valid && conn_wr_ready;
  assign overflow   = (conn_count == CW'(MAX_CONNECTIONS));
  assign accept     = mem_we && mem_ready;
  assign finish_req = finish_pending || cfg_finish;
  assign last_word  = (state == S_WR_CONN) ? (word_idx == 4'd10) : (word_idx == 4'd3);

  // First word of a burst is issued from idle; afterwards the next word is
  // loaded on the cycle the current one is accepted.
  assign sel_idx = mem_we ? (word_idx + 4'd1) : word_idx;

  always_comb begin
    rec_word = '0;
    if (sel_idx < 4'd9)
      rec_word = rec_buf[sel_idx];
    else if (sel_idx == 4'd9)
      rec_word = {31'b0, rec_up};
  end

  always_comb begin
    hdr_word = '0;
    case (sel_idx)
      4'd0:    hdr_word = MAGIC;
      4'd1:    hdr_word = version_q;
      4'd2:    hdr_word = 32'(conn_count);
      4'd3:    hdr_word = timestamp_q;
      default: hdr_word = '0;
    endcase
  end

  assign rec_base   = BASE_ADDR + ADDR_WIDTH'(16) + ADDR_WIDTH'(conn_count) * ADDR_WIDTH'(44);
  assign issue_addr = ((state == S_WR_HDR) ? BASE_ADDR : rec_base) + ADDR_WIDTH'({sel_idx, 2'b00});
  assign issue_data = (state == S_WR_HDR) ? hdr_word : rec_word;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (cfg_start) state_nxt = S_OPEN;
      S_OPEN: begin
        if (hs && !overflow)  state_nxt = S_WR_CONN;
        else if (finish_req)  state_nxt = S_WR_HDR;
      end
      S_WR_CONN: if (accept && last_word) state_nxt = finish_req ? S_WR_HDR : S_OPEN;
      S_WR_HDR:  if (accept && last_word) state_nxt = S_DONE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    conn_wr_ready = (state == S_OPEN) && !finish_pending;
    busy          = (state == S_WR_CONN) || (state == S_WR_HDR);
    done          = (state == S_DONE);
  end

  // session registers and memory write port
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_we         <= 1'b0;
      word_idx       <= '0;
      conn_count     <= '0;
      write_error    <= 1'b0;
      finish_pending <= 1'b0;
      version_q      <= '0;
      timestamp_q    <= '0;
    end else begin
      if (cfg_finish && (state == S_OPEN || state == S_WR_CONN))
        finish_pending <= 1'b1;
      if (state_nxt == S_DONE)
        finish_pending <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (cfg_start) begin
            version_q   <= cfg_version;
            timestamp_q <= cfg_timestamp;
            conn_count  <= '0;
            write_error <= 1'b0;
          end
        end
        S_OPEN: begin
          word_idx <= '0;
          if (hs && overflow) write_error <= 1'b1;
        end
        S_WR_CONN, S_WR_HDR: begin
          if (!mem_we) begin
            mem_we    <= 1'b1;
            mem_addr  <= issue_addr;
            mem_wdata <= issue_data;
          end else if (mem_ready) begin
            if (last_word) begin
              mem_we   <= 1'b0;
              word_idx <= '0;
              if (state == S_WR_CONN) conn_count <= conn_count + 1'b1;
            end else begin
              word_idx  <= word_idx + 4'd1;
              mem_addr  <= issue_addr;
              mem_wdata <= issue_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Record buffer, packed in image byte order on the accepting handshake.
  always_ff @(posedge clk) begin
    if (state == S_OPEN && hs && !overflow) begin
      rec_buf[0] <= conn_switch_id;
      rec_buf[1] <= conn_host_id;
      rec_buf[2] <= conn_my_ip;
      rec_buf[3] <= conn_peer_ip;
      rec_buf[4] <= {conn_peer_port, conn_my_port};
      rec_buf[5] <= {conn_peer_qp, conn_my_qp};
      rec_buf[6] <= {conn_my_mac[23:16], conn_my_mac[31:24], conn_my_mac[39:32], conn_my_mac[47:40]};
      rec_buf[7] <= {conn_peer_mac[39:32], conn_peer_mac[47:40], conn_my_mac[7:0], conn_my_mac[15:8]};
      rec_buf[8] <= {conn_peer_mac[7:0], conn_peer_mac[15:8], conn_peer_mac[23:16], conn_peer_mac[31:24]};
      rec_up     <= conn_up;
    end
  end

endmodule

// File: tb/tb_config_writer.sv
module tb_config_writer;
  localparam int MAXC = 2;
  localparam int AW   = 32;

  typedef struct packed {
    logic [31:0] switch_id, host_id, my_ip, peer_ip;
    logic [15:0] my_port, peer_port, my_qp, peer_qp;
    logic [47:0] my_mac, peer_mac;
    logic        up;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic mem_we, mem_ready;
  logic cfg_start, cfg_finish;
  logic [31:0] cfg_version, cfg_timestamp;
  logic conn_wr_valid, conn_wr_ready;
  rec_t cur;
  logic busy, done, write_error;
  logic [1:0] conn_count;

  always #5 clk = ~clk;

  config_writer #(.MAX_CONNECTIONS(MAXC), .ADDR_WIDTH(AW), .BASE_ADDR('0)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
    .cfg_start(cfg_start), .cfg_version(cfg_version), .cfg_timestamp(cfg_timestamp),
    .cfg_finish(cfg_finish),
    .conn_wr_valid(conn_wr_valid), .conn_wr_ready(conn_wr_ready),
    .conn_switch_id(cur.switch_id), .conn_host_id(cur.host_id),
    .conn_my_ip(cur.my_ip), .conn_peer_ip(cur.peer_ip),
    .conn_my_port(cur.my_port), .conn_peer_port(cur.peer_port),
    .conn_my_qp(cur.my_qp), .conn_peer_qp(cur.peer_qp),
    .conn_my_mac(cur.my_mac), .conn_peer_mac(cur.peer_mac), .conn_up(cur.up),
    .busy(busy), .done(done), .write_error(write_error), .conn_count(conn_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // memory model / write monitor
  logic [31:0] img [64];
  logic        wr_flag [64];
  logic [31:0] wlog [$];
  int nwrites = 0;
  int stall_err = 0, stall_cycles = 0;
  logic stall_chk_en = 1'b0;
  logic last_we = 1'b0, last_ready = 1'b0;
  logic [31:0] last_addr = '0, last_data = '0;
  int mem_mode = 0;  // 0: always ready, 1: pattern 1,0,0,1, 2: never ready
  int phase = 0;

  initial begin
    mem_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (mem_mode)
        0: mem_ready = 1'b1;
        1: begin
          mem_ready = (phase == 0 || phase == 3);
          phase = (phase + 1) % 4;
        end
        default: mem_ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (mem_we && mem_ready) begin
        nwrites++;
        wlog.push_back(mem_addr);
        if (mem_addr < 32'd256) begin
          img[mem_addr[7:2]]     = mem_wdata;
          wr_flag[mem_addr[7:2]] = 1'b1;
        end
      end
      if (stall_chk_en && last_we && !last_ready) begin
        stall_cycles++;
        if (mem_we !== 1'b1 || mem_addr !== last_addr || mem_wdata !== last_data) stall_err++;
      end
      last_we = mem_we; last_ready = mem_ready; last_addr = mem_addr; last_data = mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return img[a[7:2]];
  endfunction

  function automatic int pos_of(input logic [31:0] a);
    for (int i = 0; i < wlog.size(); i++) if (wlog[i] == a) return i;
    return -1;
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 64; i++) begin img[i] = '0; wr_flag[i] = 1'b0; end
    wlog.delete();
    nwrites = 0;
  endtask

  task automatic start_session(input logic [31:0] ver, input logic [31:0] ts);
    cfg_version = ver; cfg_timestamp = ts; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic finish_session();
    cfg_finish = 1'b1;
    @(negedge clk);
    cfg_finish = 1'b0;
  endtask

  task automatic push(input rec_t r, input logic fin, input string tag);
    bit got = 0;
    cur = r; conn_wr_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (conn_wr_ready) begin got = 1; break; end
      @(negedge clk);
    end
    if (got) begin
      cfg_finish = fin;
      @(negedge clk);
      cfg_finish = 1'b0;
    end
    conn_wr_valid = 1'b0;
    chk({tag, "_handshake"}, got, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 500; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk({tag, "_done"}, done, 1'b1);
  endtask

  rec_t ra, rb, rc;
  logic [31:0] exp_a [11];
  logic [31:0] hdr2 [4];

  initial begin
    ra = '{switch_id: 32'd3, host_id: 32'd7, my_ip: 32'h0A000001, peer_ip: 32'h0A000002,
           my_port: 16'h1234, peer_port: 16'h5678, my_qp: 16'h0011, peer_qp: 16'h0022,
           my_mac: 48'h001122334455, peer_mac: 48'hAABBCCDDEEFF, up: 1'b1};
    rb = '{switch_id: 32'h0B, host_id: 32'h0C, my_ip: 32'hC0A80001, peer_ip: 32'hC0A80002,
           my_port: 16'h1111, peer_port: 16'h2222, my_qp: 16'h0003, peer_qp: 16'h0004,
           my_mac: 48'h0A0B0C0D0E0F, peer_mac: 48'h102030405060, up: 1'b0};
    rc = '{switch_id: 32'hCC, host_id: 32'hCD, my_ip: 32'h1, peer_ip: 32'h2,
           my_port: 16'h1, peer_port: 16'h2, my_qp: 16'h3, peer_qp: 16'h4,
           my_mac: 48'h1, peer_mac: 48'h2, up: 1'b1};
    exp_a = '{32'd3, 32'd7, 32'h0A000001, 32'h0A000002, 32'h56781234, 32'h00220011,
              32'h33221100, 32'hBBAA5544, 32'hFFEEDDCC, 32'd1, 32'd0};
    hdr2  = '{32'h41544746, 32'd1, 32'd1, 32'h12345678};

    rst = 1'b1; cfg_start = 0; cfg_finish = 0; cfg_version = 0; cfg_timestamp = 0;
    conn_wr_valid = 0; cur = '0;
    clear_img();
    repeat (2) @(negedge clk);
    chk("por_mem_we", mem_we, 0);
    chk("por_mem_addr", mem_addr, 0);
    chk("por_mem_wdata", mem_wdata, 0);
    chk("por_ready", conn_wr_ready, 0);
    chk("por_busy", busy, 0);
    chk("por_done", done, 0);
    chk("por_err", write_error, 0);
    chk("por_count", conn_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // reset in the middle of a stalled record write
    mem_mode = 2;
    start_session(32'd9, 32'd9);
    push(ra, 1'b0, "t1");
    repeat (5) @(negedge clk);
    chk("t1_busy_pre", busy, 1);
    chk("t1_we_pre", mem_we, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_we_after", mem_we, 0);
    @(negedge clk);
    rst = 1'b0; mem_mode = 0;
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    chk("t1_ready", conn_wr_ready, 0);
    chk("t1_count", conn_count, 0);
    chk("t1_addr", mem_addr, 0);
    chk("t1_wdata", mem_wdata, 0);
    repeat (30) @(negedge clk);
    chk("t1_no_writes", nwrites, 0);
    chk("t1_we_idle", mem_we, 0);

    // one record, memory always ready
    clear_img();
    start_session(32'd1, 32'h12345678);
    push(ra, 1'b0, "t2");
    finish_session();
    wait_done("t2");
    for (int k = 0; k < 11; k++) chk($sformatf("t2_rec_w%0d", k), rd(32'h10 + 4*k), exp_a[k]);
    for (int k = 0; k < 4; k++)  chk($sformatf("t2_hdr_w%0d", k), rd(4*k), hdr2[k]);
    chk("t2_nwrites", nwrites, 15);
    chk("t2_first_addr", wlog[0], 32'h10);
    chk("t2_hdr_first", wlog[11], 32'h0);
    chk("t2_hdr_last", wlog[14], 32'hC);
    chk("t2_busy", busy, 0);
    chk("t2_count", conn_count, 1);

    // same image with mem_ready toggling 1,0,0,1
    clear_img();
    mem_mode = 1; stall_chk_en = 1'b1;
    start_session(32'd1, 32'h12345678);
    push(ra, 1'b0, "t3");
    finish_session();
    wait_done("t3");
    stall_chk_en = 1'b0; mem_mode = 0;
    for (int k = 0; k < 11; k++) chk($sformatf("t3_rec_w%0d", k), rd(32'h10 + 4*k), exp_a[k]);
    for (int k = 0; k < 4; k++)  chk($sformatf("t3_hdr_w%0d", k), rd(4*k), hdr2[k]);
    chk("t3_nwrites", nwrites, 15);
    chk("t3_stall_stable", stall_err, 0);
    chk("t3_stalls_seen", stall_cycles > 0, 1);

    // overflow: three records into a two-entry table
    clear_img();
    start_session(32'd2, 32'hCAFEF00D);
    push(ra, 1'b0, "t4a");
    push(rb, 1'b0, "t4b");
    push(rc, 1'b0, "t4c");
    finish_session();
    wait_done("t4");
    chk("t4_err", write_error, 1);
    chk("t4_count", conn_count, 2);
    chk("t4_hdr_w1", rd(32'h4), 32'd2);
    chk("t4_hdr_w2", rd(32'h8), 32'd2);
    chk("t4_no_0x68", wr_flag[26], 1'b0);
    chk("t4_nwrites", nwrites, 26);
    chk("t4_b_w0", rd(32'h3C), 32'h0B);
    chk("t4_b_w4", rd(32'h4C), 32'h22221111);
    chk("t4_b_w5", rd(32'h50), 32'h00040003);
    chk("t4_b_w6", rd(32'h54), 32'h0D0C0B0A);
    chk("t4_b_w7", rd(32'h58), 32'h20100F0E);
    chk("t4_b_w8", rd(32'h5C), 32'h60504030);
    chk("t4_b_w9", rd(32'h60), 32'd0);

    // restart from DONE clears status; header-only session
    start_session(32'd3, 32'h11111111);
    chk("t6_done_clr", done, 0);
    chk("t6_err_clr", write_error, 0);
    chk("t6_count_clr", conn_count, 0);
    clear_img();
    finish_session();
    wait_done("t6");
    chk("t6_nwrites", nwrites, 4);
    chk("t6_hdr_w0", rd(32'h0), 32'h41544746);
    chk("t6_hdr_w1", rd(32'h4), 32'd3);
    chk("t6_hdr_w2", rd(32'h8), 32'd0);
    chk("t6_hdr_w3", rd(32'hC), 32'h11111111);
    chk("t6_no_rec", wr_flag[4], 1'b0);

    // finish in the same cycle as the second record handshake
    clear_img();
    start_session(32'd5, 32'h55);
    chk("t5_done_clr", done, 0);
    push(ra, 1'b0, "t5a");
    push(rb, 1'b1, "t5b");
    wait_done("t5");
    chk("t5_hdr_w2", rd(32'h8), 32'd2);
    chk("t5_b_w0", rd(32'h3C), 32'h0B);
    chk("t5_b_w10_written", wr_flag[25], 1'b1);
    chk("t5_b_w10", rd(32'h64), 32'd0);
    chk("t5_nwrites", nwrites, 26);
    chk("t5_rec_seen", pos_of(32'h64) >= 0, 1);
    chk("t5_rec_before_hdr", pos_of(32'h64) < pos_of(32'h0), 1);
    chk("t5_err", write_error, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
